hiscore_upload: RTL and testbench

Serves core-side RAM contents back to the HPS over the ioctl upload channel: the read-side counterpart of the ROM download path (`ioctl_wr` / `ioctl_addr` / `ioctl_dout`). It sits in the emu top beside the game core. It turns HPS `ioctl_rd` strobes into single-byte reads of a dual-port RAM (hiscore/NVRAM) and returns each byte on `ioctl_din`. It holds `ioctl_wait` high while a fetch is in flight.

---
 rtl/hiscore_upload_pkg.sv | 24 ++
 rtl/hiscore_upload_if.sv | 32 +++
 rtl/hiscore_upload_checksum.sv | 40 ++++
 rtl/hiscore_upload.sv | 152 +++++++++++++++
 tb/tb_hiscore_upload.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hiscore_upload_pkg.sv
// hiscore_upload_pkg
//   Shared types and constants for the hiscore/NVRAM upload block.
//   state_e   : upload FSM state encoding (IDLE, FETCH, LOAD)
//   src_e     : where the byte loaded into ioctl_din comes from
//   FILL_BYTE : value returned for addresses outside the RAM image
//   LAT_W     : width of the RAM latency down-counter
package hiscore_upload_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LOAD  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SRC_RAM  = 2'd0,
      SRC_FILL = 2'd1,
      SRC_SUM  = 2'd2
   } src_e;

   localparam logic [7:0] FILL_BYTE = 8'hFF;
   localparam int         LAT_W     = 3;

endpackage

// File: rtl/hiscore_upload_if.sv
// hiscore_upload_if
//   Bundles the HPS ioctl upload channel and the RAM read port.
//   slave  : the upload block (consumes ioctl strobes, drives the RAM read)
//   master : the HPS / RAM side (drives strobes and RAM data)
//   Signals:
//     ioctl_upload, ioctl_rd, ioctl_addr[24:0], ioctl_index[7:0] : HPS -> block
//     ioctl_din[7:0], ioctl_wait                                 : block -> HPS
//     ram_addr[ADDR_W-1:0], ram_rd                               : block -> RAM
//     ram_data[7:0]                                              : RAM -> block
interface hiscore_upload_if #(
   parameter int ADDR_W = 10
);
   logic              ioctl_upload;
   logic              ioctl_rd;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_index;
   logic [7:0]        ioctl_din;
   logic              ioctl_wait;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd;
   logic [7:0]        ram_data;

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, ram_data,
      output ioctl_din, ioctl_wait, ram_addr, ram_rd
   );

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, ram_data,
      input  ioctl_din, ioctl_wait, ram_addr, ram_rd
   );
endinterface

// File: rtl/hiscore_upload_checksum.sv
// upload_checksum
//   8-bit running sum of the in-range bytes handed to the HPS, so that the
//   byte served at address SIZE makes the whole image sum to zero mod 256.
//   Ports:
//     clk_sys, reset_n : clock, async active-low reset
//     upload           : ioctl_upload, its rising edge clears the sum
//     clr_zero         : accepted read of address 0, clears the sum
//     add_en, add_byte : add one loaded byte
//     neg_sum          : two's complement of the sum
module upload_checksum (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       upload,
   input  logic       clr_zero,
   input  logic       add_en,
   input  logic [7:0] add_byte,
   output logic [7:0] neg_sum
);

   logic [7:0] acc;
   logic       upload_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= 8'h00;
         upload_q <= 1'b0;
      end else begin
         upload_q <= upload;
         // clear and add never coincide: a clear happens while the FSM is
         // idle, an add only while it is loading.
         if ((upload && !upload_q) || clr_zero)
            acc <= 8'h00;
         else if (add_en)
            acc <= acc + add_byte;
      end
   end

   assign neg_sum = ~acc + 8'd1;

endmodule

// File: rtl/hiscore_upload.sv
// hiscore_upload
//   Serves hiscore/NVRAM bytes to the HPS over the ioctl upload channel.
//   Each accepted ioctl_rd becomes one single-byte RAM read; the byte is
//   returned on ioctl_din while ioctl_wait covers the fetch.
//   Parameters: ADDR_W (RAM address width), SIZE (bytes served),
//               INDEX (ioctl_index answered), RAM_LATENCY (1..7).
//   Ports:
//     clk_sys  : clock
//     reset_n  : async active-low reset
//     bus      : hiscore_upload_if.slave (ioctl upload channel + RAM port)
//   Optional build macro HISCORE_UPLOAD_CHECKSUM_EN: address SIZE returns a
//   checksum byte instead of FILL_BYTE.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | waiting for an accepted read
//   FETCH | ram_rd issued, latency counter running
//   LOAD  | byte (RAM, fill or checksum) captured into ioctl_din
module hiscore_upload
   import hiscore_upload_pkg::*;
#(
   parameter int         ADDR_W      = 10,
   parameter int         SIZE        = 1024,
   parameter logic [7:0] INDEX       = 8'd4,
   parameter int         RAM_LATENCY = 2
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   hiscore_upload_if.slave  bus
);

   localparam logic [1:0]       IDLE   = ST_IDLE;
   localparam logic [1:0]       FETCH  = ST_FETCH;
   localparam logic [1:0]       LOAD   = ST_LOAD;
   localparam logic [24:0]      SIZE_A = 25'(SIZE);
   localparam logic [LAT_W-1:0] LAT_TC = LAT_W'(RAM_LATENCY - 1);

   logic [1:0]        state, state_d;
   logic [LAT_W-1:0]  cnt, cnt_d;
   src_e              src, src_d;
   logic [7:0]        din_q, din_d;
   logic              wait_q, wait_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              hit;
   logic              in_range;
   logic              is_sum;
   logic [7:0]        sum_byte;

   assign hit      = bus.ioctl_rd && bus.ioctl_upload &&
                     (bus.ioctl_index == INDEX) && (state == IDLE);
   assign in_range = bus.ioctl_addr < SIZE_A;

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
   logic clr_zero;
   logic add_en;

   assign is_sum   = bus.ioctl_addr == SIZE_A;
   assign clr_zero = hit && (bus.ioctl_addr == 25'd0);
   assign add_en   = (state == LOAD) && (src == SRC_RAM) && bus.ioctl_upload;

   upload_checksum u_checksum (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .upload   (bus.ioctl_upload),
      .clr_zero (clr_zero),
      .add_en   (add_en),
      .add_byte (bus.ram_data),
      .neg_sum  (sum_byte)
   );
`else
   assign is_sum   = 1'b0;
   assign sum_byte = FILL_BYTE;
`endif

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      src_d   = src;
      addr_d  = addr_q;
      din_d   = din_q;
      rd_d    = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               addr_d = bus.ioctl_addr[ADDR_W-1:0];
               cnt_d  = LAT_TC;
               if (in_range) begin
                  state_d = FETCH;
                  rd_d    = 1'b1;
                  src_d   = SRC_RAM;
               end else begin
                  state_d = LOAD;
                  if (is_sum)
                     src_d = SRC_SUM;
                  else
                     src_d = SRC_FILL;
               end
            end
         end
         FETCH: begin
            if (cnt == '0)
               state_d = LOAD;
            else
               cnt_d = cnt - 1'b1;
         end
         LOAD: begin
            state_d = IDLE;
            case (src)
               SRC_RAM: din_d = bus.ram_data;
               SRC_SUM: din_d = sum_byte;
               default: din_d = FILL_BYTE;
            endcase
         end
         default: state_d = IDLE;
      endcase
      // Session abort: drop back to idle, never load a half-finished byte.
      if (!bus.ioctl_upload) begin
         state_d = IDLE;
         rd_d    = 1'b0;
         din_d   = din_q;
      end
      wait_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         src    <= SRC_FILL;
         addr_q <= '0;
         din_q  <= 8'h00;
         wait_q <= 1'b0;
         rd_q   <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         src    <= src_d;
         addr_q <= addr_d;
         din_q  <= din_d;
         wait_q <= wait_d;
         rd_q   <= rd_d;
      end
   end

   assign bus.ioctl_din  = din_q;
   assign bus.ioctl_wait = wait_q;
   assign bus.ram_addr   = addr_q;
   assign bus.ram_rd     = rd_q;

endmodule

// File: tb/tb_hiscore_upload.sv
module tb_hiscore_upload;

   localparam int         AW  = 10;
   localparam int         SZ  = 1024;
   localparam int         LAT = 2;
   localparam logic [7:0] IDX = 8'd4;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_sys = ~clk_sys;

   hiscore_upload_if #(.ADDR_W(AW)) bus ();

   hiscore_upload #(
      .ADDR_W      (AW),
      .SIZE        (SZ),
      .INDEX       (IDX),
      .RAM_LATENCY (LAT)
   ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   // RAM model: a request seen at edge k is presented for sampling at edge
   // k+LAT; every other cycle the data lines carry junk.
   logic [7:0]    mem  [0:SZ-1];
   logic [7:0]    pdat [0:7];
   logic          pval [0:7];
   logic [7:0]    junk;
   int            rd_count = 0;
   logic [AW-1:0] rd_addr_seen;

   always @(posedge clk_sys) begin
      junk <= 8'($urandom);
      for (int k = 7; k > 0; k--) begin
         pdat[k] <= pdat[k-1];
         pval[k] <= pval[k-1];
      end
      pdat[0] <= mem[bus.ram_addr];
      pval[0] <= bus.ram_rd;
      if (bus.ram_rd) begin
         rd_count     <= rd_count + 1;
         rd_addr_seen <= bus.ram_addr;
      end
   end

   assign bus.ram_data = pval[LAT-1] ? pdat[LAT-1] : junk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sum    = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge; the strobe is sampled by the following posedge.
   task automatic read_check(input logic [24:0] a, input string tag, output logic [7:0] d);
      logic [7:0] e;
      int         ew, wc, nrd, base;
      logic       r1;
      if (a < SZ) begin
         if (a == 25'd0) sum = 8'h00;
         e  = mem[a[AW-1:0]];
         ew = LAT + 1;
      end else begin
         e = 8'hFF;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
         if (a == SZ) e = ~sum + 8'd1;
`endif
         ew = 1;
      end
      base            = rd_count;
      bus.ioctl_rd    = 1'b1;
      bus.ioctl_addr  = a;
      bus.ioctl_index = IDX;
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0;
      r1 = bus.ram_rd;
      wc = 0;
      while (bus.ioctl_wait && wc < 40) begin
         wc++;
         @(negedge clk_sys);
      end
      d   = bus.ioctl_din;
      nrd = rd_count - base;
      check({tag, " din"}, 32'(d), 32'(e));
      check({tag, " wait_cycles"}, 32'(wc), 32'(ew));
      check({tag, " ram_rd_count"}, 32'(nrd), (a < SZ) ? 32'd1 : 32'd0);
      check({tag, " ram_rd_first"}, 32'(r1), (a < SZ) ? 32'd1 : 32'd0);
      if (a < SZ) check({tag, " ram_addr"}, 32'(rd_addr_seen), 32'(a[AW-1:0]));
      if (a < SZ) sum = sum + e;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  d, prev, total;
      logic [24:0] a;
      int          base, sel;

      for (int i = 0; i < SZ; i++) mem[i] = 8'(i) ^ 8'h5A;
      bus.ioctl_upload = 1'b1;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = '0;
      bus.ioctl_index  = IDX;

      // reset state
      repeat (10) @(negedge clk_sys);
      check("reset din",      32'(bus.ioctl_din),  32'h00);
      check("reset wait",     32'(bus.ioctl_wait), 32'h0);
      check("reset ram_rd",   32'(bus.ram_rd),     32'h0);
      check("reset ram_addr", 32'(bus.ram_addr),   32'h0);
      reset_n = 1'b1;
      sum     = 8'h00;
      @(negedge clk_sys);

      // basic in-range, out-of-range, checksum-address reads
      read_check(25'd3, "addr3", d);
      read_check(25'd1024, "addr_size", d);
      read_check(25'd2000, "addr_oor", d);
      read_check(25'h1FFFFFF, "addr_max", d);

      // wrong index: ignored entirely
      prev = bus.ioctl_din;
      base = rd_count;
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd9; bus.ioctl_index = 8'd0;
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0; bus.ioctl_index = IDX;
      check("bad_index wait", 32'(bus.ioctl_wait), 32'h0);
      repeat (4) @(negedge clk_sys);
      check("bad_index din", 32'(bus.ioctl_din), 32'(prev));
      check("bad_index ram_rd_count", 32'(rd_count - base), 32'd0);

      // new random contents, randomized reads (back-to-back by construction)
      for (int i = 0; i < SZ; i++) mem[i] = 8'($urandom);
      for (int n = 0; n < 30; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6)      a = 25'($urandom_range(0, SZ - 1));
         else if (sel < 8) a = 25'(SZ + int'($urandom_range(0, 2)));
         else if (sel < 9) a = 25'd0;
         else              a = 25'($urandom);
         read_check(a, "rand", d);
      end

      // strobe while busy plus wrong-index strobe: only the first counts
      base = rd_count;
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd11; bus.ioctl_index = IDX;
      @(negedge clk_sys);
      bus.ioctl_addr = 25'd12;
      @(negedge clk_sys);
      bus.ioctl_addr = 25'd13; bus.ioctl_index = 8'd0;
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0; bus.ioctl_index = IDX;
      for (int w = 0; w < 40 && bus.ioctl_wait; w++) @(negedge clk_sys);
      repeat (2) @(negedge clk_sys);
      check("busy_strobe ram_rd_count", 32'(rd_count - base), 32'd1);
      check("busy_strobe din", 32'(bus.ioctl_din), 32'(mem[11]));
      check("busy_strobe wait", 32'(bus.ioctl_wait), 32'h0);
      sum = sum + mem[11];

      // full sweep; with the checksum option the image sums to zero
      total = 8'h00;
      for (int i = 0; i <= SZ; i++) begin
         read_check(25'(i), "sweep", d);
         total = total + d;
      end
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      check("sweep total", 32'(total), 32'h00);
`endif

      // upload dropped during FETCH
      prev = bus.ioctl_din;
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd5; bus.ioctl_index = IDX;
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0;
      check("drop busy wait", 32'(bus.ioctl_wait), 32'h1);
      bus.ioctl_upload = 1'b0;
      @(negedge clk_sys);
      check("drop wait", 32'(bus.ioctl_wait), 32'h0);
      check("drop ram_rd", 32'(bus.ram_rd), 32'h0);
      check("drop din", 32'(bus.ioctl_din), 32'(prev));
      repeat (4) @(negedge clk_sys);
      check("drop din hold", 32'(bus.ioctl_din), 32'(prev));
      bus.ioctl_upload = 1'b1;
      sum = 8'h00;
      @(negedge clk_sys);
      read_check(25'd1024, "after_drop size", d);
      read_check(25'd7, "after_drop addr7", d);

      // asynchronous reset mid-fetch
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd7; bus.ioctl_index = IDX;
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0;
      check("pre_reset ram_rd", 32'(bus.ram_rd), 32'h1);
      #1 reset_n = 1'b0;
      #1;
      check("async_reset din",      32'(bus.ioctl_din),  32'h00);
      check("async_reset wait",     32'(bus.ioctl_wait), 32'h0);
      check("async_reset ram_rd",   32'(bus.ram_rd),     32'h0);
      check("async_reset ram_addr", 32'(bus.ram_addr),   32'h0);
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      sum = 8'h00;
      @(negedge clk_sys);
      read_check(25'd1024, "post_reset size", d);
      read_check(25'd0, "post_reset addr0", d);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
